// File: rtl/port_uart_pkg.sv
// Shared types and line levels for the port B UART transmitter.
package port_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/port_b_uart_tx_fifo.sv
// Small synchronous byte FIFO; pointers carry one extra bit so count can reach DEPTH.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/port_b_uart_tx.sv
// Captures CPU port B writes into a byte FIFO and shifts them out as UART 8N1.
module port_b_uart_tx
   import port_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          clr_ovf,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_full,
   output logic                          overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t   state;
   logic [BW-1:0] baud;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic [7:0]  fifo_dout;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        baud_done;

   // Handshake: wr_en is a valid with no ready (the CPU cannot stall). A byte is
   // taken whenever push is high, which includes a full FIFO that is popping in
   // the same cycle; otherwise the byte is dropped and overflow latches.
   assign pop       = (state == IDLE) && !fifo_empty;
   assign push      = wr_en && (!fifo_full || pop);
   assign baud_done = (baud == BAUD_LAST);

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped write beats a same-cycle clear so no loss goes unreported.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_en && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= UART_IDLE_LVL;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx <= UART_IDLE_LVL;
               if (pop) begin
                  shift <= fifo_dout;
                  baud  <= '0;
                  state <= START;
                  tx    <= UART_START_LVL;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (baud_done) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= shift[0];
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= UART_IDLE_LVL;
                  end else begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud  <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  tx    <= UART_IDLE_LVL;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= UART_IDLE_LVL;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_b_uart_tx.sv
// Directed bench for port_b_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_port_b_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          clr_ovf;
   logic          tx;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   port_b_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .clr_ovf    (clr_ovf),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Samples one 40-cycle frame from index 'first'; index 0 is the first cycle tx is low.
   task automatic rx_frame(input string tag, input logic [7:0] b, input int first);
      logic [39:0] exp_tx, obs_tx, obs_busy, mask;
      exp_tx = '0; obs_tx = '0; obs_busy = '0; mask = '0;
      for (int i = 0; i < 40; i++) begin
         if (i < 4)       exp_tx[i] = 1'b0;
         else if (i < 36) exp_tx[i] = b[(i - 4) / 4];
         else             exp_tx[i] = 1'b1;
         if (i >= first) begin
            mask[i]     = 1'b1;
            obs_tx[i]   = tx;
            obs_busy[i] = busy;
            @(negedge clk);
         end
      end
      check({tag, "_tx"}, obs_tx, exp_tx & mask);
      check({tag, "_busy"}, obs_busy, mask);
   endtask

   task automatic gap(input string tag);
      check({tag, "_gap_tx"}, tx, 1'b1);
      check({tag, "_gap_busy"}, busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic quiet(input string tag);
      logic low_seen;
      low_seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
      end
      check({tag, "_quiet"}, low_seen, 1'b0);
   endtask

   initial begin
      logic full_seen;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_full", fifo_full, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Single byte
      strobe(8'hA5);
      check("a5_count1", fifo_count, 1);
      check("a5_pre_tx", tx, 1'b1);
      check("a5_pre_busy", busy, 1'b0);
      @(negedge clk);
      check("a5_popped", fifo_count, 0);
      rx_frame("a5", 8'hA5, 0);
      check("a5_end_busy", busy, 1'b0);
      check("a5_end_tx", tx, 1'b1);
      check("a5_end_count", fifo_count, 0);

      // Burst of four consecutive writes
      full_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr_data = 8'(k + 1);
         wr_en   = 1'b1;
         @(negedge clk);
         full_seen |= fifo_full;
      end
      wr_en = 1'b0;
      check("burst_count", fifo_count, 3);
      check("burst_full_seen", full_seen, 1'b0);
      check("burst_ovf", overflow, 1'b0);
      rx_frame("b1", 8'h01, 2);
      gap("b1");
      rx_frame("b2", 8'h02, 0);
      gap("b2");
      rx_frame("b3", 8'h03, 0);
      gap("b3");
      rx_frame("b4", 8'h04, 0);
      check("burst_end_count", fifo_count, 0);
      check("burst_end_ovf", overflow, 1'b0);

      // Overflow during an in-flight frame
      strobe(8'h10);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         wr_data = 8'h11 + 8'(k);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("ovf_set", overflow, 1'b1);
      check("ovf_count", fifo_count, 4);
      check("ovf_full", fifo_full, 1'b1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 1'b0);
      rx_frame("o0", 8'h10, 6);
      gap("o0");
      rx_frame("o1", 8'h11, 0);
      gap("o1");
      rx_frame("o2", 8'h12, 0);
      gap("o2");
      rx_frame("o3", 8'h13, 0);
      gap("o3");
      rx_frame("o4", 8'h14, 0);
      check("ovf_end_count", fifo_count, 0);
      quiet("ovf");

      // Full FIFO written in the same cycle the FSM pops
      strobe(8'h20);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         wr_data = 8'h21 + 8'(k);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("fp_count4", fifo_count, 4);
      check("fp_full", fifo_full, 1'b1);
      rx_frame("f0", 8'h20, 4);
      check("fp_idle_busy", busy, 1'b0);
      check("fp_idle_count", fifo_count, 4);
      strobe(8'h25);
      check("fp_count_kept", fifo_count, 4);
      check("fp_ovf", overflow, 1'b0);
      rx_frame("f1", 8'h21, 0);
      gap("f1");
      rx_frame("f2", 8'h22, 0);
      gap("f2");
      rx_frame("f3", 8'h23, 0);
      gap("f3");
      rx_frame("f4", 8'h24, 0);
      gap("f4");
      rx_frame("f5", 8'h25, 0);
      check("fp_end_count", fifo_count, 0);

      // Reset during DATA bit 3 with two bytes queued
      strobe(8'h30);
      @(negedge clk);
      strobe(8'h31);
      strobe(8'h32);
      repeat (15) @(negedge clk);
      check("mr_pre_count", fifo_count, 2);
      check("mr_pre_busy", busy, 1'b1);
      check("mr_pre_tx", tx, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_tx", tx, 1'b1);
      check("mr_busy", busy, 1'b0);
      check("mr_count", fifo_count, 0);
      check("mr_ovf", overflow, 1'b0);
      quiet("mr");

      // Dropped write collides with clr_ovf
      strobe(8'h40);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         wr_data = 8'h41 + 8'(k);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_data = 8'h45;
      wr_en   = 1'b1;
      clr_ovf = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      check("col_ovf", overflow, 1'b1);
      check("col_count", fifo_count, 4);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("col_clear", overflow, 1'b0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("final_count", fifo_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/port_b_uart_tx.md
Name: port_b_uart_tx

Overview:
- Downstream consumer of the CPU's port B output register.
- Every port B write (MOVWF to address 0x0D) is captured as a byte, buffered in a small FIFO, and serialized as UART 8N1 on a single tx pin.
- The DE0-CV board uses it to stream program output to a host terminal.
- The CPU cannot stall, so overflow is flagged rather than back-pressured.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the buffer; power of two, at least 2.

Ports:
- clk  in  1  system clock, same as CPU.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  one-cycle strobe; driven by the CPU's load_port_b.
- wr_data  in  8  byte to send; driven by the CPU databus, sampled when wr_en=1.
- clr_ovf  in  1  clears the overflow flag.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is being shifted (state other than IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes buffered.
- fifo_full  out  1  fifo_count==FIFO_DEPTH.
- overflow  out  1  sticky; a write was dropped.

Behaviour:
- Reset is synchronous on clk, active-high on rst. All state is cleared on a rst edge, including mid-frame:
  - tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0.
  - FIFO pointers 0, state IDLE, bit/baud counters 0.
  - A partial frame is abandoned; tx returns high the cycle after the reset edge.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - push = wr_en & (!full | pop). A write while full with a pop in the same cycle is accepted.
  - A write while full with no pop is dropped and sets overflow=1 at that edge.
  - Pointers wrap modulo FIFO_DEPTH. Count is pointer-difference based: +1 on push only, -1 on pop only, unchanged on both.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0, pop, load shift register with the head byte, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. After CLKS_PER_BIT cycles, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing and latency:
  - The baud counter counts 0..CLKS_PER_BIT-1; the bit advances on the terminal count.
  - tx is registered, glitch-free.
  - Latency: wr_en sampled at edge N into an empty FIFO with FSM in IDLE gives fifo_count=1 after edge N, pop and START at edge N+1, tx low from edge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between back-to-back frames.
- overflow:
  - Cleared by clr_ovf at an edge.
  - A same-cycle dropped write wins over clr_ovf, so overflow stays 1.
- wr_data of a write accepted into the FIFO is frozen; later port B writes never alter a queued or in-flight byte.

Decomposition:
- Package port_uart_pkg holds:
  - The state enum typedef tx_state_t {IDLE, START, DATA, STOP}.
  - Localparam constants UART_IDLE_LVL=1'b1 and UART_START_LVL=1'b0.
- One sub-module is natural: byte_fifo (parameter DEPTH).
  - Ports clk, rst, push, pop, din[7:0], dout[7:0], count, full, empty.
  - port_b_uart_tx instantiates byte_fifo and contains the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: rst, then wr_en with 0xA5 -> tx low 1 cycle after the strobe edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. busy=1 for exactly 40 cycles; fifo_count returns to 0.
- Burst: write 0x01, 0x02, 0x03, 0x04 on consecutive cycles -> first frame starts, fifo_full never asserts (first pop precedes the 4th write), overflow=0. Four frames decode in order, each separated by exactly 1 idle-high cycle.
- Overflow: during the first frame write 5 more bytes (the FIFO already holds 0) -> the 5th write is dropped and overflow=1. clr_ovf pulse -> overflow=0. Only 4 bytes plus the in-flight byte are transmitted.
- Full with simultaneous pop: fill the FIFO to 4 while busy. Write in the same cycle the FSM returns to IDLE and pops -> write accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame: rst asserted during DATA bit 3 with 2 bytes queued -> next cycle tx=1, busy=0, fifo_count=0, and no further frames.
- clr_ovf collision: clr_ovf and a dropped write in the same cycle -> overflow=1.
